// File: rtl/riscv_v_pkg.sv
// Shared types for the vector mask-logical datapath: the mask register type,
// the mask-logical opcode, the decoded ALU control bundle and its decoder.
package riscv_v_pkg;

    localparam int VLEN      = 32;
    localparam int MASK_OP_W = 3;
    localparam int OPCODE_W  = 7;

    typedef logic [VLEN-1:0] riscv_v_mask_t;

    typedef enum logic [MASK_OP_W-1:0] {
        MASK_AND  = 3'd0,
        MASK_NAND = 3'd1,
        MASK_ANDN = 3'd2,
        MASK_XOR  = 3'd3,
        MASK_OR   = 3'd4,
        MASK_NOR  = 3'd5,
        MASK_ORN  = 3'd6,
        MASK_XNOR = 3'd7
    } riscv_v_mask_op_e;

    typedef struct packed {
        logic is_and;
        logic is_or;
        logic is_xor;
        logic neg_srca;
        logic neg_result;
    } riscv_v_mask_ctrl_t;

    // Exactly one of is_and/is_or/is_xor is set; anything unrecognised
    // degrades to a plain AND so the ALU never sees an empty function select.
    function automatic riscv_v_mask_ctrl_t riscv_v_mask_decode(input riscv_v_mask_op_e op);
        riscv_v_mask_ctrl_t c;
        c = '0;
        case (op)
            MASK_AND:  c.is_and = 1'b1;
            MASK_NAND: begin c.is_and = 1'b1; c.neg_result = 1'b1; end
            MASK_ANDN: begin c.is_and = 1'b1; c.neg_srca   = 1'b1; end
            MASK_XOR:  c.is_xor = 1'b1;
            MASK_XNOR: begin c.is_xor = 1'b1; c.neg_result = 1'b1; end
            MASK_OR:   c.is_or  = 1'b1;
            MASK_NOR:  begin c.is_or  = 1'b1; c.neg_result = 1'b1; end
            MASK_ORN:  begin c.is_or  = 1'b1; c.neg_srca   = 1'b1; end
            default:   c.is_and = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/riscv_v_mask_ALU_if.sv
// Connection between the mask-logical sequencer (system side) and the mask
// ALU. srca carries vs1, srcb carries vs2; result is combinational in the ALU.
interface riscv_v_mask_ALU_if;
    import riscv_v_pkg::*;

    logic          is_mask;
    logic          is_and;
    logic          is_or;
    logic          is_xor;
    logic          neg_srca;
    logic          neg_result;
    riscv_v_mask_t srca;
    riscv_v_mask_t srcb;
    riscv_v_mask_t result;
`ifdef RISCV_V_INST
    logic [OPCODE_W-1:0] opcode;
`endif

    modport system (
        input  result,
        output is_mask, is_and, is_or, is_xor, neg_srca, neg_result, srca, srcb
`ifdef RISCV_V_INST
        , output opcode
`endif
    );

    modport alu (
        output result,
        input  is_mask, is_and, is_or, is_xor, neg_srca, neg_result, srca, srcb
`ifdef RISCV_V_INST
        , input opcode
`endif
    );

endinterface

// File: rtl/riscv_v_mask_tail_merge.sv
// Tail-undisturbed merge: bits below vl come from the ALU result, bits at or
// above vl keep the old destination contents. vl larger than the register
// width simply selects the whole result.
module riscv_v_mask_tail_merge #(
    parameter int MASK_W = 32,
    parameter int VL_W   = $clog2(MASK_W) + 1
) (
    input  logic [MASK_W-1:0] result_i,
    input  logic [MASK_W-1:0] old_vd_i,
    input  logic [VL_W-1:0]   vl_i,
    output logic [MASK_W-1:0] data_o
);

    logic [MASK_W-1:0] body;

    // Element i is active when i < vl; comparing against vl directly also
    // covers vl >= MASK_W, so no explicit clamp is needed.
    for (genvar i = 0; i < MASK_W; i++) begin : g_body
        assign body[i] = (vl_i > VL_W'(i));
    end

    assign data_o = (result_i & body) | (old_vd_i & ~body);

endmodule

// File: rtl/riscv_v_mask_alu_seq.sv
// Two-stage issue/retire sequencer around the vector mask ALU. Stage 1 holds
// the decoded instruction and drives the ALU; stage 2 captures the
// tail-merged result and presents it to writeback.
module riscv_v_mask_alu_seq
    import riscv_v_pkg::*;
#(
    parameter int MASK_W = $bits(riscv_v_mask_t),
    parameter int VD_W   = 5,
    parameter int VL_W   = $clog2(MASK_W) + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  riscv_v_mask_op_e    in_op,
    input  logic [MASK_W-1:0]   in_vs1,
    input  logic [MASK_W-1:0]   in_vs2,
    input  logic [MASK_W-1:0]   in_old_vd,
    input  logic [VL_W-1:0]     in_vl,
    input  logic [VD_W-1:0]     in_vd_idx,
`ifdef RISCV_V_INST
    input  logic [OPCODE_W-1:0] in_opcode,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [VD_W-1:0]     out_vd_idx,
    output logic [MASK_W-1:0]   out_data,
    riscv_v_mask_ALU_if.system  alu_if
);

    logic               s1_valid_q,  s1_valid_d;
    riscv_v_mask_ctrl_t s1_ctrl_q,   s1_ctrl_d;
    logic [MASK_W-1:0]  s1_srca_q,   s1_srca_d;
    logic [MASK_W-1:0]  s1_srcb_q,   s1_srcb_d;
    logic [MASK_W-1:0]  s1_old_vd_q, s1_old_vd_d;
    logic [VL_W-1:0]    s1_vl_q,     s1_vl_d;
    logic [VD_W-1:0]    s1_vd_idx_q, s1_vd_idx_d;
`ifdef RISCV_V_INST
    logic [OPCODE_W-1:0] s1_opcode_q, s1_opcode_d;
`endif

    logic               s2_valid_q,  s2_valid_d;
    logic [MASK_W-1:0]  s2_data_q,   s2_data_d;
    logic [VD_W-1:0]    s2_vd_idx_q, s2_vd_idx_d;

    logic               s1_ready;
    logic               s2_ready;
    logic               in_fire;
    logic               s1_advance;
    logic [MASK_W-1:0]  merged;

    // A stage can take new data when it is empty or its contents move on in
    // the same edge; flush and reset block acceptance outright.
    assign s2_ready   = !s2_valid_q | out_ready;
    assign s1_ready   = !s1_valid_q | s2_ready;
    assign in_ready   = s1_ready & !flush & rst_n;
    assign in_fire    = in_valid & in_ready;
    assign s1_advance = s1_valid_q & s2_ready;

    // Stage 1 next state: load on accept, empty on advance or flush.
    always_comb begin
        // NOTE: every _d starts from its _q so no path leaves a value unassigned and no latch is inferred.
        s1_valid_d  = s1_valid_q;
        s1_ctrl_d   = s1_ctrl_q;
        s1_srca_d   = s1_srca_q;
        s1_srcb_d   = s1_srcb_q;
        s1_old_vd_d = s1_old_vd_q;
        s1_vl_d     = s1_vl_q;
        s1_vd_idx_d = s1_vd_idx_q;
`ifdef RISCV_V_INST
        s1_opcode_d = s1_opcode_q;
`endif
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (in_fire) begin
            s1_valid_d  = 1'b1;
            s1_ctrl_d   = riscv_v_mask_decode(in_op);
            s1_srca_d   = in_vs1;
            s1_srcb_d   = in_vs2;
            s1_old_vd_d = in_old_vd;
            s1_vl_d     = in_vl;
            s1_vd_idx_d = in_vd_idx;
`ifdef RISCV_V_INST
            s1_opcode_d = in_opcode;
`endif
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
        // An idle ALU sees all-zero controls.
        if (!s1_valid_d) begin
            s1_ctrl_d = '0;
        end
    end

    // Stage 2 next state: capture the merged result, release on writeback.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_vd_idx_d = s2_vd_idx_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_advance) begin
            s2_valid_d  = 1'b1;
            s2_data_d   = merged;
            s2_vd_idx_d = s1_vd_idx_q;
        end else if (out_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_ctrl_q   <= '0;
            s1_srca_q   <= '0;
            s1_srcb_q   <= '0;
            s1_old_vd_q <= '0;
            s1_vl_q     <= '0;
            s1_vd_idx_q <= '0;
`ifdef RISCV_V_INST
            s1_opcode_q <= '0;
`endif
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_vd_idx_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s1_srca_q   <= s1_srca_d;
            s1_srcb_q   <= s1_srcb_d;
            s1_old_vd_q <= s1_old_vd_d;
            s1_vl_q     <= s1_vl_d;
            s1_vd_idx_q <= s1_vd_idx_d;
`ifdef RISCV_V_INST
            s1_opcode_q <= s1_opcode_d;
`endif
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_vd_idx_q <= s2_vd_idx_d;
        end
    end

    assign alu_if.is_mask    = s1_valid_q;
    assign alu_if.is_and     = s1_ctrl_q.is_and;
    assign alu_if.is_or      = s1_ctrl_q.is_or;
    assign alu_if.is_xor     = s1_ctrl_q.is_xor;
    assign alu_if.neg_srca   = s1_ctrl_q.neg_srca;
    assign alu_if.neg_result = s1_ctrl_q.neg_result;
    assign alu_if.srca       = s1_srca_q;
    assign alu_if.srcb       = s1_srcb_q;
`ifdef RISCV_V_INST
    assign alu_if.opcode     = s1_opcode_q;
`endif

    riscv_v_mask_tail_merge #(
        .MASK_W (MASK_W),
        .VL_W   (VL_W)
    ) u_tail_merge (
        .result_i (alu_if.result),
        .old_vd_i (s1_old_vd_q),
        .vl_i     (s1_vl_q),
        .data_o   (merged)
    );

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_vd_idx = s2_vd_idx_q;

endmodule

// File: tb/tb_riscv_v_mask_alu_seq.sv
// Self-checking bench for riscv_v_mask_alu_seq: a behavioural mask ALU sits
// on the interface, a scoreboard tracks accepted instructions against
// emitted results, and directed sequences cover latency, backpressure,
// flush and reset.
module tb_riscv_v_mask_alu_seq;
    import riscv_v_pkg::*;

    localparam int MASK_W = VLEN;
    localparam int VD_W   = 5;
    localparam int VL_W   = $clog2(MASK_W) + 1;
    localparam int NVEC   = 14;

    typedef logic [MASK_W-1:0] mask_t;

    typedef struct packed {
        logic [VD_W-1:0] idx;
        mask_t           data;
    } exp_t;

    typedef struct {
        riscv_v_mask_op_e op;
        mask_t            vs1;
        mask_t            vs2;
        mask_t            old_vd;
        logic [VL_W-1:0]  vl;
        logic [VD_W-1:0]  vd;
        mask_t            exp;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    riscv_v_mask_op_e in_op;
    mask_t            in_vs1;
    mask_t            in_vs2;
    mask_t            in_old_vd;
    logic [VL_W-1:0]  in_vl;
    logic [VD_W-1:0]  in_vd_idx;
    logic             out_valid;
    logic             out_ready;
    logic [VD_W-1:0]  out_vd_idx;
    mask_t            out_data;
`ifdef RISCV_V_INST
    logic [OPCODE_W-1:0] in_opcode = 7'h57;
`endif

    riscv_v_mask_ALU_if alu_if ();

    int    tests_run    = 0;
    int    tests_failed = 0;
    int    out_fires    = 0;
    int    run_len      = 0;
    int    max_run      = 0;
    exp_t  sb_q[$];
    exp_t  exp_next;
    exp_t  sb_e;
    vec_t  vecs[NVEC];
    mask_t alu_a;
    mask_t alu_r;

    always #5 clk = ~clk;

    riscv_v_mask_alu_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_vs1     (in_vs1),
        .in_vs2     (in_vs2),
        .in_old_vd  (in_old_vd),
        .in_vl      (in_vl),
        .in_vd_idx  (in_vd_idx),
`ifdef RISCV_V_INST
        .in_opcode  (in_opcode),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_vd_idx (out_vd_idx),
        .out_data   (out_data),
        .alu_if     (alu_if)
    );

    // Behavioural mask ALU: srca = vs1 (optionally inverted), srcb = vs2.
    always_comb begin
        alu_a = alu_if.neg_srca ? ~alu_if.srca : alu_if.srca;
        alu_r = '0;
        if (alu_if.is_and)      alu_r = alu_a & alu_if.srcb;
        else if (alu_if.is_or)  alu_r = alu_a | alu_if.srcb;
        else if (alu_if.is_xor) alu_r = alu_a ^ alu_if.srcb;
        if (alu_if.neg_result)  alu_r = ~alu_r;
        alu_if.result = alu_r;
    end

    // Reference: RVV mask-logical semantics (vd = vs2 op vs1) with tail-undisturbed merge.
    function automatic mask_t ref_model(input riscv_v_mask_op_e op, input mask_t vs1,
                                        input mask_t vs2, input mask_t old_vd,
                                        input logic [VL_W-1:0] vl);
        mask_t r;
        case (op)
            MASK_AND:  r = vs2 & vs1;
            MASK_NAND: r = ~(vs2 & vs1);
            MASK_ANDN: r = vs2 & ~vs1;
            MASK_XOR:  r = vs2 ^ vs1;
            MASK_OR:   r = vs2 | vs1;
            MASK_NOR:  r = ~(vs2 | vs1);
            MASK_ORN:  r = vs2 | ~vs1;
            MASK_XNOR: r = ~(vs2 ^ vs1);
            default:   r = vs2 & vs1;
        endcase
        for (int i = 0; i < MASK_W; i++) begin
            if (i >= int'(vl)) r[i] = old_vd[i];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_inputs(input riscv_v_mask_op_e op, input mask_t vs1, input mask_t vs2,
                              input mask_t old_vd, input logic [VL_W-1:0] vl,
                              input logic [VD_W-1:0] vd, input mask_t exp);
        in_op         = op;
        in_vs1        = vs1;
        in_vs2        = vs2;
        in_old_vd     = old_vd;
        in_vl         = vl;
        in_vd_idx     = vd;
        exp_next.idx  = vd;
        exp_next.data = exp;
        in_valid      = 1'b1;
    endtask

    task automatic rand_inputs(input logic [VD_W-1:0] vd);
        riscv_v_mask_op_e op;
        mask_t            vs1, vs2, old_vd;
        logic [VL_W-1:0]  vl;
        op     = riscv_v_mask_op_e'(3'($urandom_range(7)));
        vs1    = $urandom;
        vs2    = $urandom;
        old_vd = $urandom;
        vl     = VL_W'($urandom_range(40));
        set_inputs(op, vs1, vs2, old_vd, vl, vd, ref_model(op, vs1, vs2, old_vd, vl));
    endtask

    // Wait (bounded) until the presented instruction is accepted; returns #1 after that edge.
    task automatic wait_accept();
        int budget = 50;
        do begin
            @(negedge clk);
            budget--;
        end while (!in_ready && budget > 0);
        if (!in_ready) check("accept timeout in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input riscv_v_mask_op_e op, input mask_t vs1, input mask_t vs2,
                         input mask_t old_vd, input logic [VL_W-1:0] vl,
                         input logic [VD_W-1:0] vd, input mask_t exp);
        set_inputs(op, vs1, vs2, old_vd, vl, vd, exp);
        wait_accept();
    endtask

    task automatic wait_drain();
        int budget = 40;
        while ((sb_q.size() != 0 || out_valid) && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        check("drain scoreboard entries left", sb_q.size(), 0);
    endtask

    function automatic logic [5:0] alu_ctrl();
        return {alu_if.is_mask, alu_if.is_and, alu_if.is_or, alu_if.is_xor,
                alu_if.neg_srca, alu_if.neg_result};
    endfunction

    // Scoreboard monitor: inputs are stable at the falling edge, so fires seen
    // here are exactly the transfers of the following rising edge.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst_n || flush) begin
                sb_q.delete();
                run_len = 0;
            end else begin
                if (out_valid && out_ready) begin
                    out_fires++;
                    run_len++;
                    if (run_len > max_run) max_run = run_len;
                    if (sb_q.size() == 0) begin
                        tests_run++;
                        tests_failed++;
                        $display("FAIL unexpected output: got vd=%0d data=0x%0h, expected none",
                                 out_vd_idx, out_data);
                    end else begin
                        sb_e = sb_q.pop_front();
                        check("out_data", out_data, sb_e.data);
                        check("out_vd_idx", out_vd_idx, sb_e.idx);
                    end
                end else begin
                    run_len = 0;
                end
                if (in_valid && in_ready) sb_q.push_back(exp_next);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int    accepted;
        int    changes;
        int    fires_before;
        logic  took;
        logic  held_valid;
        mask_t held;

        vecs[0]  = '{MASK_ANDN, 32'h000000FF, 32'h0000FFFF, 32'h00000000, 6'd32, 5'd2,  32'h0000FF00};
        vecs[1]  = '{MASK_XNOR, 32'h00001234, 32'h00001234, 32'h00000000, 6'd32, 5'd3,  32'hFFFFFFFF};
        vecs[2]  = '{MASK_OR,   32'h0000000F, 32'h00000000, 32'hFFFFFFFF, 6'd4,  5'd4,  32'hFFFFFFFF};
        vecs[3]  = '{MASK_OR,   32'h00000005, 32'h00000000, 32'hFFFF0000, 6'd4,  5'd5,  32'hFFFF0005};
        vecs[4]  = '{MASK_XOR,  32'h0000AAAA, 32'h00005555, 32'h13572468, 6'd0,  5'd6,  32'h13572468};
        vecs[5]  = '{MASK_NAND, 32'hFFFF0000, 32'h0F0F0F0F, 32'hDEADBEEF, 6'd37, 5'd7,  32'hF0F0FFFF};
        vecs[6]  = '{MASK_NOR,  32'h00000000, 32'h00000000, 32'h00000000, 6'd32, 5'd8,  32'hFFFFFFFF};
        vecs[7]  = '{MASK_ORN,  32'hFFFF0000, 32'h00000001, 32'h00000000, 6'd32, 5'd9,  32'h0000FFFF};
        vecs[8]  = '{MASK_NAND, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hABCDFFFF, 6'd16, 5'd10, 32'hABCD0000};
        vecs[9]  = '{MASK_AND,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 6'd31, 5'd11, 32'h7FFFFFFF};
        vecs[10] = '{MASK_XOR,  32'h00000003, 32'h00000000, 32'h00000000, 6'd1,  5'd12, 32'h00000001};
        vecs[11] = '{MASK_ANDN, 32'hFFFF0000, 32'h12345678, 32'h00000000, 6'd63, 5'd31, 32'h00005678};
        vecs[12] = '{MASK_XNOR, 32'h0F0F0F0F, 32'h00FF00FF, 32'h00000000, 6'd32, 5'd0,  32'hF00FF00F};
        vecs[13] = '{MASK_AND,  32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 6'd8,  5'd13, 32'hFFFFFF00};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = MASK_AND;
        in_vs1    = '0;
        in_vs2    = '0;
        in_old_vd = '0;
        in_vl     = '0;
        in_vd_idx = '0;
        exp_next  = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset in_ready", in_ready, 1'b0);
        check("reset out_valid", out_valid, 1'b0);
        check("reset out_data", out_data, '0);
        check("reset out_vd_idx", out_vd_idx, '0);
        check("reset alu controls", alu_ctrl(), 6'b0);
        check("reset alu srca", alu_if.srca, '0);
        check("reset alu srcb", alu_if.srcb, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single VMAND: accepted at edge N, visible after edge N+1.
        set_inputs(MASK_AND, 32'h0000F0F0, 32'h0000FF00, 32'h0, 6'd32, 5'd1, 32'h0000F000);
        @(negedge clk);
        check("t1 in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("t1 out_valid after edge N", out_valid, 1'b0);
        check("t1 alu controls in s1", alu_ctrl(), 6'b110000);
        @(posedge clk);
        #1;
        check("t1 out_valid after edge N+1", out_valid, 1'b1);
        check("t1 out_data", out_data, 32'h0000F000);
        check("t1 out_vd_idx", out_vd_idx, 5'd1);
        check("t1 alu controls idle", alu_ctrl(), 6'b0);
        wait_drain();

        // Table vectors, back to back.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].vs1, vecs[i].vs2, vecs[i].old_vd,
                  vecs[i].vl, vecs[i].vd, vecs[i].exp);
        end
        in_valid = 1'b0;
        wait_drain();

        // Ten random ops back to back: ten results on consecutive cycles.
        max_run = 0;
        for (int i = 0; i < 10; i++) begin
            rand_inputs(VD_W'(i));
            wait_accept();
        end
        in_valid = 1'b0;
        wait_drain();
        check("b2b consecutive outputs", max_run, 10);

        // Backpressure: out_ready low for 5 cycles, only two accepts, output held.
        out_ready  = 1'b0;
        accepted   = 0;
        changes    = 0;
        held_valid = 1'b0;
        held       = '0;
        rand_inputs(5'd14);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            took = in_ready;
            if (took) accepted++;
            if (out_valid) begin
                if (!held_valid) begin
                    held       = out_data;
                    held_valid = 1'b1;
                end else if (out_data !== held) begin
                    changes++;
                end
            end
            @(posedge clk);
            #1;
            if (took) rand_inputs(VD_W'(15 + accepted));
        end
        check("bp accepts", accepted, 2);
        check("bp in_ready held low", in_ready, 1'b0);
        check("bp out_valid held", out_valid, 1'b1);
        check("bp out_data changes", changes, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Flush with two in flight and a new op offered on the same edge.
        out_ready = 1'b0;
        rand_inputs(5'd20);
        wait_accept();
        rand_inputs(5'd21);
        wait_accept();
        out_ready = 1'b1;
        flush     = 1'b1;
        rand_inputs(5'd22);
        @(negedge clk);
        check("flush in_ready", in_ready, 1'b0);
        check("flush out_valid before edge", out_valid, 1'b1);
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush out_valid after edge", out_valid, 1'b0);
        fires_before = out_fires;
        repeat (4) @(posedge clk);
        #1;
        check("flush nothing emitted", out_fires - fires_before, 0);

        // Reset in the middle of a stream.
        for (int i = 0; i < 3; i++) begin
            rand_inputs(VD_W'(24 + i));
            wait_accept();
        end
        rand_inputs(5'd27);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("midreset out_valid", out_valid, 1'b0);
        check("midreset out_data", out_data, '0);
        check("midreset out_vd_idx", out_vd_idx, '0);
        check("midreset alu controls", alu_ctrl(), 6'b0);
        check("midreset alu srca", alu_if.srca, '0);
        check("midreset alu srcb", alu_if.srcb, '0);
        @(negedge clk);
        check("midreset in_ready second cycle", in_ready, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(MASK_NOR, 32'h0, 32'h0, 32'h5A5A5A5A, 6'd32, 5'd17, 32'hFFFFFFFF);
        in_valid = 1'b0;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
